// File: rtl/mem_fill_responder_if.sv
// Line-fill request/beat bus plus byte write port between the cache side and the
// memory responder.
interface mem_fill_responder_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int BLK_W  = 3
);
    logic                      req;
    logic [ADDR_W-BLK_W-1:0]   req_addr;
    logic                      busy;
    logic                      rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [BLK_W-1:0]          rblk;
    logic                      rlast;
    logic                      done;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;

    modport master (
        output req, req_addr, wr_en, wr_addr, wr_data,
        input  busy, rvalid, rdata, rblk, rlast, done
    );

    modport slave (
        input  req, req_addr, wr_en, wr_addr, wr_data,
        output busy, rvalid, rdata, rblk, rlast, done
    );
endinterface

// File: rtl/mem_fill_responder.sv
// Main-memory responder for cache line fills: after LAT idle cycles streams the
// 2**BLK_W bytes of the requested line, one registered beat per cycle.
module mem_fill_responder #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int BLK_W  = 3,
    parameter int LAT    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_fill_responder_if.slave  bus
);
    localparam int LINE_W = ADDR_W - BLK_W;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_t             state_reg;
    logic [LINE_W-1:0]  base_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic [BLK_W-1:0]   blk_reg;
    logic               busy_reg;
    logic               rvalid_reg;
    logic [DATA_W-1:0]  rdata_reg;
    logic [BLK_W-1:0]   rblk_reg;
    logic               rlast_reg;
    logic               done_reg;

    // Write port is independent of the FSM; a same-edge write to the beat
    // address lands in the array while the beat register captures the old byte.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            wait_cnt_reg <= '0;
            blk_reg      <= '0;
            busy_reg     <= 1'b0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rblk_reg     <= '0;
            rlast_reg    <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.req) begin
                        base_reg <= bus.req_addr;
                        busy_reg <= 1'b1;
                        blk_reg  <= '0;
                        if (LAT == 0) begin
                            state_reg <= BURST;
                        end else begin
                            wait_cnt_reg <= CNT_W'(LAT);
                            state_reg    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Leaving on count 1 places beat 0 exactly LAT+1 edges after acceptance.
                    if (wait_cnt_reg == CNT_W'(1)) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= BURST;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
                    end
                end
                BURST: begin
                    rvalid_reg <= 1'b1;
                    rblk_reg   <= blk_reg;
                    rdata_reg  <= mem[{base_reg, blk_reg}];
                    rlast_reg  <= (blk_reg == '1);
                    blk_reg    <= blk_reg + BLK_W'(1);
                    if (blk_reg == '1) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    rvalid_reg <= 1'b0;
                    rlast_reg  <= 1'b0;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.rvalid = rvalid_reg;
    assign bus.rdata  = rdata_reg;
    assign bus.rblk   = rblk_reg;
    assign bus.rlast  = rlast_reg;
    assign bus.done   = done_reg;
endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench for mem_fill_responder: one LAT=2 and one LAT=0 instance share
// the write port; sel picks which instance the stimulus and checks address.
module tb_mem_fill_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        req_v;
    logic [7:0]  req_addr_v;
    logic        wr_en_v;
    logic [10:0] wr_addr_v;
    logic [7:0]  wr_data_v;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [63:0] EXP_A = 64'h1716151413121110;
    localparam logic [63:0] EXP_E = 64'h171615EE13121110;
    localparam logic [63:0] EXP_F = 64'hA7A6A5A4A3A2A1A0;

    mem_fill_responder_if #(.ADDR_W(11), .DATA_W(8), .BLK_W(3)) bus2 ();
    mem_fill_responder_if #(.ADDR_W(11), .DATA_W(8), .BLK_W(3)) bus0 ();

    mem_fill_responder #(.ADDR_W(11), .DATA_W(8), .BLK_W(3), .LAT(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );
    mem_fill_responder #(.ADDR_W(11), .DATA_W(8), .BLK_W(3), .LAT(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    assign bus2.req      = req_v & ~sel;
    assign bus0.req      = req_v & sel;
    assign bus2.req_addr = req_addr_v;
    assign bus0.req_addr = req_addr_v;
    assign bus2.wr_en    = wr_en_v;
    assign bus0.wr_en    = wr_en_v;
    assign bus2.wr_addr  = wr_addr_v;
    assign bus0.wr_addr  = wr_addr_v;
    assign bus2.wr_data  = wr_data_v;
    assign bus0.wr_data  = wr_data_v;

    wire       o_busy   = sel ? bus0.busy   : bus2.busy;
    wire       o_rvalid = sel ? bus0.rvalid : bus2.rvalid;
    wire [7:0] o_rdata  = sel ? bus0.rdata  : bus2.rdata;
    wire [2:0] o_rblk   = sel ? bus0.rblk   : bus2.rblk;
    wire       o_rlast  = sel ? bus0.rlast  : bus2.rlast;
    wire       o_done   = sel ? bus0.done   : bus2.done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [10:0] a, input logic [7:0] d);
        wr_en_v   = 1'b1;
        wr_addr_v = a;
        wr_data_v = d;
        tick();
        wr_en_v   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   o_busy,   0);
        chk({tag, "_rvalid"}, o_rvalid, 0);
        chk({tag, "_rdata"},  o_rdata,  0);
        chk({tag, "_rblk"},   o_rblk,   0);
        chk({tag, "_rlast"},  o_rlast,  0);
        chk({tag, "_done"},   o_done,   0);
    endtask

    // One request; edge c after acceptance is checked against the burst timeline.
    task automatic burst(input logic [7:0] line, input int lat, input logic [63:0] exp,
                         input bit stray, input int wr_beat, input int abort_c);
        int  k;
        bit  aborted = 1'b0;
        req_addr_v = line;
        req_v      = 1'b1;
        tick();
        req_v      = 1'b0;
        req_addr_v = 8'h00;
        chk("acc_busy", o_busy, 1);
        chk("acc_rvalid", o_rvalid, 0);
        for (int c = 1; c <= lat + 10; c++) begin
            if (stray && (c == 5 || c == lat + 9)) req_v = 1'b1;
            if (wr_beat >= 0 && c == lat + 1 + wr_beat) begin
                wr_en_v   = 1'b1;
                wr_addr_v = {line, 3'(wr_beat)};
                wr_data_v = 8'hEE;
            end
            tick();
            req_v   = 1'b0;
            wr_en_v = 1'b0;
            if (c <= lat) begin
                chk("wait_rvalid", o_rvalid, 0);
                chk("wait_busy", o_busy, 1);
            end else if (c <= lat + 8) begin
                k = c - lat - 1;
                chk("beat_rvalid", o_rvalid, 1);
                chk("beat_rblk", o_rblk, k);
                chk("beat_rdata", o_rdata, exp[8*k +: 8]);
                chk("beat_rlast", o_rlast, (k == 7) ? 1 : 0);
                chk("beat_busy", o_busy, 1);
                chk("beat_done", o_done, 0);
            end else if (c == lat + 9) begin
                chk("done_pulse", o_done, 1);
                chk("done_busy", o_busy, 0);
                chk("done_rvalid", o_rvalid, 0);
                chk("done_rlast", o_rlast, 0);
                chk("done_rdata_hold", o_rdata, exp[63:56]);
            end else begin
                chk("post_done", o_done, 0);
                chk("post_busy", o_busy, 0);
            end
            if (c == abort_c) begin
                reset = 1'b0;
                #1;
                chk_all_zero("abort");
                repeat (3) begin
                    tick();
                    chk("abort_no_done", o_done, 0);
                    chk("abort_no_beat", o_rvalid, 0);
                end
                reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        $display("burst line=%02h lat=%0d stray=%0d wr_beat=%0d aborted=%0d", line, lat, stray, wr_beat, aborted);
    endtask

    // Continuous req: exactly two acceptances and two complete bursts.
    task automatic back_to_back(input int lat);
        int   acc = 0;
        int   dones = 0;
        int   beats = 0;
        logic prev_busy;
        req_addr_v = 8'h15;
        req_v      = 1'b1;
        prev_busy  = o_busy;
        for (int c = 0; c <= 2 * lat + 19; c++) begin
            tick();
            if (o_busy && !prev_busy) begin
                acc++;
                chk("b2b_accept_edge", c, (acc == 1) ? 0 : lat + 10);
            end
            prev_busy = o_busy;
            if (o_rvalid) beats++;
            if (o_done) dones++;
        end
        req_v = 1'b0;
        chk("b2b_accepts", acc, 2);
        chk("b2b_beats", beats, 16);
        chk("b2b_dones", dones, 2);
        tick();
        chk("b2b_idle_busy", o_busy, 0);
        $display("back_to_back lat=%0d accepts=%0d beats=%0d dones=%0d", lat, acc, beats, dones);
    endtask

    initial begin
        reset      = 1'b0;
        sel        = 1'b0;
        req_v      = 1'b0;
        req_addr_v = 8'h00;
        wr_en_v    = 1'b0;
        wr_addr_v  = 11'h000;
        wr_data_v  = 8'h00;
        repeat (3) tick();
        chk_all_zero("rst2");
        sel = 1'b1;
        #1;
        chk_all_zero("rst0");
        sel = 1'b0;
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            wr(11'h0A8 + 11'(i), 8'h10 + 8'(i));
            wr(11'h7F8 + 11'(i), 8'hA0 + 8'(i));
            wr(11'h000 + 11'(i), 8'h55);
        end

        burst(8'h15, 2, EXP_A, 1'b0, -1, -1);
        burst(8'h15, 2, EXP_A, 1'b1, -1, -1);
        burst(8'h15, 2, EXP_A, 1'b0, -1, 5);
        burst(8'h15, 2, EXP_A, 1'b0, -1, -1);
        burst(8'h15, 2, EXP_A, 1'b0, 4, -1);
        burst(8'h15, 2, EXP_E, 1'b0, -1, -1);
        wr(11'h0AC, 8'h14);

        sel = 1'b1;
        tick();
        burst(8'hFF, 0, EXP_F, 1'b0, -1, -1);

        sel = 1'b0;
        tick();
        back_to_back(2);
        sel = 1'b1;
        tick();
        back_to_back(0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
